c17_bist_ctrl: RTL and testbench
================================

Name: c17_bist_ctrl

Overview:
- Self-test controller that wraps the locked ISCAS-85 c17 netlist.
- Upstream role: drives the 5-bit input vector {I1,I2,I3,I4,I5}, exhaustively by default.
- Downstream role: compacts {O1,O2} into a 16-bit MISR signature and compares it with a golden value.
- Replaces the per-vector truth-table dump with a single pass/fail verdict, used to check that a key/unlock configuration reproduces the unlocked function.

Parameters:
- NUM_PATTERNS, 32: vectors applied per run; legal range 1..32.
- SETTLE_CYCLES, 1: cycles pat_out is held before resp_in is sampled; legal range 1..15.
- GOLDEN_SIG, 16'h0000: expected final signature. The integrator sets it from the unlocked c17 model.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle run request
- pat_out  out  5  applied vector; bit4=I1 … bit0=I5
- resp_in  in  2  circuit response; bit1=O1, bit0=O2
- busy  out  1  run in progress
- done  out  1  run finished; held until next start or rst
- pass  out  1  signature==GOLDEN_SIG; valid only while done=1, else 0
- signature  out  16  current MISR contents

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, pat_out=5'b0, busy=0, done=0, pass=0, signature=16'h0000, pattern index=0, settle counter=0.
- FSM states: IDLE, APPLY, CAPTURE, DONE.
  - IDLE: start=1 → APPLY; index=0, MISR=0, settle=0.
  - APPLY: pat_out=index (zero-extended). Settle counter increments. When the counter reaches SETTLE_CYCLES → CAPTURE.
  - CAPTURE, single cycle:
    - MISR updates from resp_in.
    - If index==NUM_PATTERNS-1 → DONE.
    - Else index+1 and settle counter cleared → APPLY.
  - DONE: done=1, pass=(signature==GOLDEN_SIG), pat_out holds the last vector. start=1 → restart as from IDLE (done/pass drop next cycle).
- busy=1 in APPLY and CAPTURE only.
- MISR, Fibonacci, polynomial x^16+x^14+x^13+x^11+1:
  - fb = s[15]^s[13]^s[12]^s[10]
  - s_next = {s[14:0],fb} ^ {14'b0,resp_in}
  - Updates only in CAPTURE; otherwise holds.
- Latency: the first APPLY cycle is the cycle after start is sampled. done rises exactly NUM_PATTERNS*(SETTLE_CYCLES+1)+1 cycles after the start-sampling edge. Defaults give 65.
- Boundaries:
  - start while busy: ignored.
  - start and rst in the same cycle: rst wins.
  - rst mid-run: back to IDLE with all outputs at reset values next cycle; no partial verdict.
  - Index never wraps; it stops at NUM_PATTERNS-1.
  - Out-of-range parameters: elaboration error via generate-time check.

Optional Feature:
- Macro: C17_BIST_LFSR_EN.
- Defined:
  - Pattern source is a 5-bit Fibonacci LFSR, x^5+x^3+1, seed 5'b00001, advanced in CAPTURE.
  - The first 31 vectors are the LFSR sequence. Vector 32, when NUM_PATTERNS=32, is 5'b00000, so the run stays exhaustive.
  - Index counter still governs termination.
- Undefined: binary up-counter, vectors 0,1,2,…

Decomposition:
- Package c17_bist_pkg:
  - state enum: IDLE/APPLY/CAPTURE/DONE
  - MISR_W=16
  - MISR tap constant 16'hB400, marking bits 15,13,12,10
  - PAT_W=5, RESP_W=2
  - LFSR seed/tap constants
- Sub-module c17_misr: clk, rst, clr, en, din[1:0], sig[15:0]. Reused later for the other ISCAS-85 wrappers.

Test Plan:
- Exhaustive sequence: rst, start pulse; record pat_out at each CAPTURE → 0,1,…,31; done at cycle 65 after start; busy high for 64 cycles.
- Zero response: resp_in tied 2'b00, GOLDEN_SIG=0 → signature 16'h0000, pass=1.
- Single error: resp_in=2'b01 only at index-31 CAPTURE → signature 16'h0001, pass=0. Repeat with 2'b10 → 16'h0002.
- Real c17: connect the unlocked c17; set GOLDEN_SIG to the value the bench computes from its reference model → pass=1. Flip one key bit to the wrong value → pass=0.
- Reset mid-run: rst at cycle 20 → next cycle busy=0, done=0, signature=0, pat_out=0. A fresh start gives the same final signature as an uninterrupted run.
- start during busy, and start in DONE: a pulse at cycle 10 is ignored, done still at 65. A pulse in DONE restarts, done drops, a second done arrives at +65 with an identical signature.
- C17_BIST_LFSR_EN: pat_out sequence begins 01,02,05,0A,… (bench LFSR model); final vector 00; all 32 distinct values seen.

Source files
------------

// File: rtl/c17_bist_pkg.sv
// Shared types and constants for the c17 self-test controller and its MISR.
// LFSR constants are consumed by c17_bist_ctrl when C17_BIST_LFSR_EN is defined.
package c17_bist_pkg;

   typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, DONE} state_e;

   localparam int MISR_W = 16;
   localparam int PAT_W  = 5;
   localparam int RESP_W = 2;

   // x^16+x^14+x^13+x^11+1: feedback taps at bits 15,13,12,10
   localparam logic [MISR_W-1:0] MISR_TAPS = 16'hB400;

   // x^5+x^3+1 Fibonacci LFSR, shift left, feedback from bits 4 and 1
   localparam logic [PAT_W-1:0] LFSR_SEED = 5'b00001;
   localparam logic [PAT_W-1:0] LFSR_TAPS = 5'b10010;

   function automatic logic [PAT_W-1:0] lfsr_step(input logic [PAT_W-1:0] s);
      return {s[PAT_W-2:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/c17_misr.sv
// 16-bit Fibonacci MISR compacting a 2-bit response stream; clr and rst force zero.
module c17_misr
   import c17_bist_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [RESP_W-1:0] din,
   output logic [MISR_W-1:0] sig
);

   logic [MISR_W-1:0] sig_q, sig_d;

   always_comb begin
      sig_d = sig_q;
      if (clr)
         sig_d = '0;
      else if (en)
         sig_d = {sig_q[MISR_W-2:0], ^(sig_q & MISR_TAPS)} ^ {{(MISR_W-RESP_W){1'b0}}, din};
   end

   always_ff @(posedge clk) begin
      if (rst) sig_q <= '0;
      else     sig_q <= sig_d;
   end

   assign sig = sig_q;

endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST controller for the locked c17 netlist: applies vectors, compacts responses, gives a verdict.
// Define C17_BIST_LFSR_EN to source vectors from a 5-bit LFSR instead of a binary counter.
module c17_bist_ctrl
   import c17_bist_pkg::*;
#(
   parameter int                NUM_PATTERNS  = 32,
   parameter int                SETTLE_CYCLES = 1,
   parameter logic [MISR_W-1:0] GOLDEN_SIG    = 16'h0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [PAT_W-1:0]  pat_out,
   input  logic [RESP_W-1:0] resp_in,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [MISR_W-1:0] signature
);

   if (NUM_PATTERNS < 1 || NUM_PATTERNS > 32) begin : g_bad_num_patterns
      $error("c17_bist_ctrl: NUM_PATTERNS must be in 1..32");
   end
   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("c17_bist_ctrl: SETTLE_CYCLES must be in 1..15");
   end

   localparam logic [4:0] LAST_IDX = 5'(NUM_PATTERNS - 1);
   localparam logic [3:0] SETTLE_N = 4'(SETTLE_CYCLES);

`ifdef C17_BIST_LFSR_EN
   localparam logic [PAT_W-1:0] FIRST_PAT = LFSR_SEED;
`else
   localparam logic [PAT_W-1:0] FIRST_PAT = '0;
`endif

   state_e           state_q, state_d;
   logic [4:0]       idx_q, idx_d;
   logic [3:0]       settle_q, settle_d;
   logic [PAT_W-1:0] pat_q, pat_d, pat_next;
   logic             done_q, pass_q;
   logic             misr_clr, misr_en;
   logic [MISR_W-1:0] sig;

`ifdef C17_BIST_LFSR_EN
   // the LFSR never produces zero, so the 32nd vector is forced to 0 to stay exhaustive
   assign pat_next = (idx_q == 5'd30) ? '0 : lfsr_step(pat_q);
`else
   assign pat_next = pat_q + 1'b1;
`endif

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      settle_d = settle_q;
      pat_d    = pat_q;
      misr_clr = 1'b0;
      misr_en  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d  = APPLY;
               idx_d    = '0;
               settle_d = '0;
               pat_d    = FIRST_PAT;
               misr_clr = 1'b1;
            end
         end
         APPLY: begin
            settle_d = settle_q + 1'b1;
            if (settle_d == SETTLE_N) state_d = CAPTURE;
         end
         CAPTURE: begin
            misr_en = 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end else begin
               state_d  = APPLY;
               idx_d    = idx_q + 1'b1;
               settle_d = '0;
               pat_d    = pat_next;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         settle_q <= '0;
         pat_q    <= '0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         settle_q <= settle_d;
         pat_q    <= pat_d;
         // verdict registered one cycle after entering DONE; a restart drops it immediately
         done_q   <= (state_q == DONE) && !start;
         pass_q   <= (state_q == DONE) && !start && (sig == GOLDEN_SIG);
      end
   end

   c17_misr u_misr (
      .clk (clk),
      .rst (rst),
      .clr (misr_clr),
      .en  (misr_en),
      .din (resp_in),
      .sig (sig)
   );

   assign pat_out   = pat_q;
   assign busy      = (state_q == APPLY) || (state_q == CAPTURE);
   assign done      = done_q;
   assign pass      = pass_q;
   assign signature = sig;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Directed bench for c17_bist_ctrl: full runs against a keyed c17 model and forced responses.
module tb_c17_bist_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, key;
   int          mode;
   logic [4:0]  pat, pat_z;
   logic [1:0]  resp;
   logic        busy, done, pass, busy_z, done_z, pass_z;
   logic [15:0] sig, sig_z;
   int          nvec = 0;
   int          nfail = 0;

   always #5 clk = ~clk;

   function automatic logic [4:0] vec(input int k);
      logic [4:0] s;
`ifdef C17_BIST_LFSR_EN
      if (k == 31) return 5'b00000;
      s = 5'b00001;
      for (int i = 0; i < k; i++) s = {s[3:0], s[4] ^ s[1]};
`else
      s = 5'(k);
`endif
      return s;
   endfunction

   // c17 with one XNOR key gate on N10; correct key is 1
   function automatic logic [1:0] c17(input logic [4:0] p, input logic k);
      logic n10, n11, n16, n19, n22, n23;
      n10 = ~(p[4] & p[2]) ^ ~k;
      n11 = ~(p[2] & p[1]);
      n16 = ~(p[3] & n11);
      n19 = ~(n11 & p[0]);
      n22 = ~(n10 & n16);
      n23 = ~(n16 & n19);
      return {n22, n23};
   endfunction

   function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [1:0] r);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ {14'b0, r};
   endfunction

   function automatic logic [15:0] golden(input logic k);
      logic [15:0] s;
      s = 16'h0000;
      for (int i = 0; i < 32; i++) s = misr_step(s, c17(vec(i), k));
      return s;
   endfunction

   localparam logic [15:0] GOLD    = golden(1'b1);
   localparam logic [4:0]  LASTPAT = vec(31);

   always_comb begin
      resp = 2'b00;
      case (mode)
         0: resp = c17(pat, key);
         2: resp = (pat == LASTPAT) ? 2'b01 : 2'b00;
         3: resp = (pat == LASTPAT) ? 2'b10 : 2'b00;
         default: resp = 2'b00;
      endcase
   end

   c17_bist_ctrl #(.NUM_PATTERNS(32), .SETTLE_CYCLES(1), .GOLDEN_SIG(GOLD)) u_dut (
      .clk(clk), .rst(rst), .start(start), .pat_out(pat), .resp_in(resp),
      .busy(busy), .done(done), .pass(pass), .signature(sig));

   c17_bist_ctrl #(.NUM_PATTERNS(32), .SETTLE_CYCLES(1), .GOLDEN_SIG(16'h0000)) u_dz (
      .clk(clk), .rst(rst), .start(start), .pat_out(pat_z), .resp_in(resp),
      .busy(busy_z), .done(done_z), .pass(pass_z), .signature(sig_z));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // issues start, then watches edge t (sampled at the following negedge) until both done
   task automatic run(input int m, input logic k, input int poke_t,
                      output int lat, output int lat_z, output int bcnt, output int perr,
                      output logic [31:0] seen, output logic d0);
      mode = m; key = k;
      lat = -1; lat_z = -1; bcnt = 0; perr = 0; seen = '0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      d0 = done;
      for (int t = 0; t < 200 && (lat < 0 || lat_z < 0); t++) begin
         start = (t == poke_t);
         if (busy) bcnt++;
         if (t < 64) begin
            if (pat !== vec(t / 2) || pat_z !== vec(t / 2)) perr++;
            if (t % 2 == 1) seen[pat] = 1'b1;
         end
         if (done && lat < 0) lat = t;
         if (done_z && lat_z < 0) lat_z = t;
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   typedef struct {
      int          mode;
      logic        key;
      logic [15:0] sig;
      logic        pass;
   } tv_t;

   tv_t         tbl[5];
   int          lat, lat_z, bcnt, perr;
   logic [31:0] seen;
   logic        d0;

   initial begin
      tbl[0] = '{1, 1'b1, 16'h0000, 1'b0};
      tbl[1] = '{2, 1'b1, 16'h0001, 1'b0};
      tbl[2] = '{3, 1'b1, 16'h0002, 1'b0};
      tbl[3] = '{0, 1'b1, GOLD,        1'b1};
      tbl[4] = '{0, 1'b0, golden(1'b0), 1'b0};

      rst = 1'b1; start = 1'b0; mode = 1; key = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {8'b0, busy, done, pass, pat, sig}, 32'h0);
      chk("reset_sig_z", {16'b0, sig_z}, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         run(tbl[i].mode, tbl[i].key, -1, lat, lat_z, bcnt, perr, seen, d0);
         chk($sformatf("v%0d_done_latency", i), lat, 65);
         chk($sformatf("v%0d_done_latency_z", i), lat_z, 65);
         chk($sformatf("v%0d_busy_cycles", i), bcnt, 64);
         chk($sformatf("v%0d_pattern_errs", i), perr, 0);
         chk($sformatf("v%0d_patterns_seen", i), seen, 32'hFFFF_FFFF);
         chk($sformatf("v%0d_signature", i), sig, tbl[i].sig);
         chk($sformatf("v%0d_signature_z", i), sig_z, tbl[i].sig);
         chk($sformatf("v%0d_pass", i), pass, tbl[i].pass);
         chk($sformatf("v%0d_pass_z", i), pass_z, tbl[i].sig == 16'h0000);
      end

      // restart from DONE: done drops at once, identical second signature
      run(0, 1'b1, -1, lat, lat_z, bcnt, perr, seen, d0);
      chk("restart_done_drop", d0, 1'b0);
      chk("restart_latency", lat, 65);
      chk("restart_signature", sig, GOLD);
      chk("restart_pass", pass, 1'b1);

      // start pulse at cycle 10 while busy is ignored
      run(0, 1'b1, 9, lat, lat_z, bcnt, perr, seen, d0);
      chk("busy_start_latency", lat, 65);
      chk("busy_start_busy_cycles", bcnt, 64);
      chk("busy_start_signature", sig, GOLD);

      // reset mid-run, then a clean run reproduces the golden signature
      mode = 0; key = 1'b1;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrun_reset_outputs", {8'b0, busy, done, pass, pat, sig}, 32'h0);
      rst = 1'b0;
      run(0, 1'b1, -1, lat, lat_z, bcnt, perr, seen, d0);
      chk("after_reset_latency", lat, 65);
      chk("after_reset_signature", sig, GOLD);
      chk("after_reset_pass", pass, 1'b1);

      // start and rst together: reset wins
      @(negedge clk); rst = 1'b1; start = 1'b1;
      @(negedge clk);
      chk("rst_start_same_cycle", {busy, done, pass}, 3'b000);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("rst_start_stays_idle", {busy, done, sig}, 18'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
